// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller with an embedded simple dual-port
// RAM (synchronous write, registered 1-cycle read) and a 2-entry prefetch buffer
// providing first-word-fall-through output at full throughput.
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   din, in_valid       push data / request; in_ready accepts the push
//   dout, out_valid     head-of-FIFO word and its valid flag
//   out_ready           pop request, honoured while out_valid is high
//   count               words held in RAM + in-flight read + prefetch buffer
module sync_fifo_ctrl #(
    parameter int unsigned addr_width = 6,
    parameter int unsigned data_width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] din,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [addr_width:0]   count
);

    localparam int unsigned depth = 1 << addr_width;
    localparam int unsigned cnt_w = addr_width + 1;

    logic [data_width-1:0] r_mem [depth];

    logic [addr_width-1:0] r_wptr;
    logic [addr_width-1:0] r_rptr;
    logic [cnt_w-1:0]      r_ram_cnt;   // words written but not yet fetched
    logic [cnt_w-1:0]      r_count;
    logic                  r_inflight;  // r_rdata holds a word fetched at the last edge
    logic [data_width-1:0] r_rdata;     // RAM read-port register
    logic [data_width-1:0] r_pf [2];
    logic [1:0]            r_pf_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_fetch;
    logic [1:0]            w_head;
    logic [data_width-1:0] w_pf_nxt [2];
    logic [1:0]            w_pf_cnt_nxt;

    // in_ready held low during reset; otherwise not full
    assign in_ready  = rst_n && (r_count < cnt_w'(depth));
    // The head is the oldest prefetch entry, or the freshly read word when the buffer is empty
    assign out_valid = (r_pf_cnt != 2'd0) || r_inflight;
    assign dout      = ((r_pf_cnt == 2'd0) && r_inflight) ? r_rdata : r_pf[0];
    assign count     = r_count;

    assign w_push  = in_valid && in_ready;
    assign w_pop   = out_valid && out_ready;
    assign w_head  = r_pf_cnt + {1'b0, r_inflight};
    // Fetch only words written at earlier edges, and only if the buffer will have room
    assign w_fetch = (r_ram_cnt != '0) && ((w_head - {1'b0, w_pop}) < 2'd2);

    // Prefetch buffer update: remove popped head, then append the arriving read word
    always_comb begin
        w_pf_nxt     = r_pf;
        w_pf_cnt_nxt = r_pf_cnt;
        if (w_pop && (r_pf_cnt != 2'd0)) begin
            w_pf_nxt[0]  = r_pf[1];
            w_pf_cnt_nxt = r_pf_cnt - 2'd1;
        end
        // A read word popped directly from r_rdata never enters the buffer
        if (r_inflight && !(w_pop && (r_pf_cnt == 2'd0))) begin
            if (w_pf_cnt_nxt == 2'd0) begin
                w_pf_nxt[0] = r_rdata;
            end else begin
                w_pf_nxt[1] = r_rdata;
            end
            w_pf_cnt_nxt = w_pf_cnt_nxt + 2'd1;
        end
    end

    // RAM write port; contents are not reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers, occupancy, read register and prefetch state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_rdata    <= '0;
            r_pf[0]    <= '0;
            r_pf[1]    <= '0;
            r_pf_cnt   <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + addr_width'(1);
            end
            if (w_fetch) begin
                r_rptr  <= r_rptr + addr_width'(1);
                r_rdata <= r_mem[r_rptr];
            end
            r_inflight <= w_fetch;
            r_ram_cnt  <= r_ram_cnt + cnt_w'(w_push) - cnt_w'(w_fetch);
            r_count    <= r_count + cnt_w'(w_push) - cnt_w'(w_pop);
            r_pf       <= w_pf_nxt;
            r_pf_cnt   <= w_pf_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (DEPTH = 64, 6-bit words).
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] din;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] dout;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo_ctrl #(.addr_width(6), .data_width(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs driven 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        step();
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
        step();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++;
        if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++;
        if (dout !== 6'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    endtask

    task automatic test_single();
        din = 6'h2A; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (count !== 7'd1) begin n_fail++; $display("FAIL single_count_e0: got %0d want 1", count); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_e0: got %b want 0", out_valid); end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || dout !== 6'h2A) begin
            n_fail++; $display("FAIL single_head: got v=%b d=%h want v=1 d=2a", out_valid, dout);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_pop: got cnt=%0d v=%b want cnt=0 v=0", count, out_valid);
        end
    endtask

    task automatic test_fill_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            din = 6'(i); in_valid = 1'b1;
            step();
        end
        n_tests++;
        if (count !== 7'd64 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got cnt=%0d rdy=%b want cnt=64 rdy=0", count, in_ready);
        end
        din = 6'h3F; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (count !== 7'd64) begin n_fail++; $display("FAIL overflow_ignored: got cnt=%0d want 64", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || dout !== 6'(i)) begin
                n_fail++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, dout, 6'(i));
            end
            step();
        end
        out_ready = 1'b0;
        n_tests++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got cnt=%0d v=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_stream_wrap();
        for (int k = 0; k < 200; k++) begin
            din = 6'(k % 64); in_valid = 1'b1; out_ready = 1'b1;
            n_tests++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_%0d: got %b want 1", k, in_ready); end
            if (k >= 2) begin
                n_tests++;
                if (out_valid !== 1'b1 || dout !== 6'((k - 2) % 64)) begin
                    n_fail++; $display("FAIL stream_out_%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, dout, 6'((k - 2) % 64));
                end
            end
            step();
            n_tests++;
            if (count !== ((k >= 1) ? 7'd2 : 7'd1)) begin
                n_fail++; $display("FAIL stream_count_%0d: got %0d want %0d", k, count, (k >= 1) ? 2 : 1);
            end
        end
        in_valid = 1'b0;
        for (int k = 198; k < 200; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || dout !== 6'(k % 64)) begin
                n_fail++; $display("FAIL stream_tail_%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, dout, 6'(k % 64));
            end
            step();
        end
        out_ready = 1'b0;
        n_tests++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_empty: got cnt=%0d v=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            din = 6'(i); in_valid = 1'b1;
            step();
        end
        din = 6'h11; in_valid = 1'b1; out_ready = 1'b1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready0: got %b want 0", in_ready); end
        step();
        n_tests++;
        if (count !== 7'd63) begin n_fail++; $display("FAIL fullpop_count1: got %0d want 63", count); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready1: got %b want 1", in_ready); end
        din = 6'h22;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (count !== 7'd63) begin n_fail++; $display("FAIL fullpop_count2: got %0d want 63", count); end
        // Words 0 and 1 were popped; 6'h11 was rejected, 6'h22 accepted last
        for (int i = 2; i < 65; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || dout !== ((i == 64) ? 6'h22 : 6'(i))) begin
                n_fail++; $display("FAIL fullpop_drain_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, dout, (i == 64) ? 6'h22 : 6'(i));
            end
            step();
        end
        out_ready = 1'b0;
        n_tests++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL fullpop_empty: got cnt=%0d v=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = 6'(i + 5); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        n_tests++;
        if (count !== 7'd10) begin n_fail++; $display("FAIL mid_count10: got %0d want 10", count); end
        rst_n = 1'b0; in_valid = 1'b1; din = 6'h3C; out_ready = 1'b1;
        step();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got cnt=%0d v=%b want 0 0", count, out_valid);
        end
        din = 6'h15; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || dout !== 6'h15 || count !== 7'd1) begin
            n_fail++; $display("FAIL mid_first_out: got v=%b d=%h cnt=%0d want v=1 d=15 cnt=1", out_valid, dout, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_empty: got cnt=%0d v=%b want 0 0", count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_stream_wrap();
        test_full_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
